// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control FSM.
package mc_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned HOLD_W  = 4;

  typedef enum logic [STATE_W-1:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EX_R   = 4'd3,
    S_WB_R   = 4'd4,
    S_EX_I   = 4'd5,
    S_WB_I   = 4'd6,
    S_ADDR   = 4'd7,
    S_MEM_RD = 4'd8,
    S_MEM_WR = 4'd9,
    S_WB_MEM = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_MEM = 3'd1,
    CLS_BR  = 3'd2,
    CLS_J   = 3'd3,
    CLS_I   = 3'd4,
    CLS_ILL = 3'd5
  } instr_cls_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] EXT_SIGN = 2'b00;
  localparam logic [1:0] EXT_ZERO = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // Control word driven to the datapath each cycle.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [1:0] ext_op;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational opcode classifier: instruction class, extender mode, legality.
module mc_opcode_decode
  import mc_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output instr_cls_e      cls_c,
  output logic [1:0]      ext_op_c,
  output logic            legal_c
);

  always_comb begin
    cls_c    = CLS_ILL;
    ext_op_c = EXT_SIGN;
    legal_c  = 1'b1;
    case (opcode)
      OP_RTYPE:        cls_c = CLS_R;
      OP_LW, OP_SW:    cls_c = CLS_MEM;
      OP_BEQ, OP_BNE:  cls_c = CLS_BR;
      OP_J:            cls_c = CLS_J;
      OP_ADDI, OP_SLTI: cls_c = CLS_I;
      OP_ANDI, OP_ORI: begin
        cls_c    = CLS_I;
        ext_op_c = EXT_ZERO;
      end
      OP_LUI: begin
        cls_c    = CLS_I;
        ext_op_c = EXT_LUI;
      end
      default:         legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath: fetch, decode, execute,
// memory and write-back sequencing with a memory-ready stall handshake.
module multi_cycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned RESET_VECTOR_HOLD = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            pc_write_cond,
  output logic            branch_ne,
  output logic            iord,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_op,
  output logic [1:0]      pc_source,
  output logic [1:0]      ext_op,
  output logic            illegal_op,
  output logic [STATE_W-1:0] state
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_VECTOR_HOLD - 1);

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  ctrl_t             ctrl_c;
  instr_cls_e        cls_c;
  logic [1:0]        dec_ext_c;
  logic              legal_c;

  // The branch condition is resolved in the datapath from pc_write_cond/branch_ne.
  logic unused_zero;
  assign unused_zero = zero;

  mc_opcode_decode u_decode (
    .opcode   (opcode),
    .cls_c    (cls_c),
    .ext_op_c (dec_ext_c),
    .legal_c  (legal_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RST;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ctrl_c  = '0;
    case (state_q)
      S_RST: begin
        if (hold_q == HOLD_LAST) begin
          state_d = S_FETCH;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.ir_write  = mem_ready;
        ctrl_c.pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl_c.alu_src_b  = SRCB_IMM_SH;
        ctrl_c.illegal_op = ~legal_c;
        case (cls_c)
          CLS_R:   state_d = S_EX_R;
          CLS_MEM: state_d = S_ADDR;
          CLS_BR:  state_d = S_BRANCH;
          CLS_J:   state_d = S_JUMP;
          CLS_I:   state_d = S_EX_I;
          default: state_d = S_FETCH;
        endcase
      end
      S_EX_R: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_B;
        ctrl_c.alu_op    = ALUOP_FUNCT;
        state_d          = S_WB_R;
      end
      S_WB_R: begin
        ctrl_c.reg_dst   = 1'b1;
        ctrl_c.reg_write = 1'b1;
        state_d          = S_FETCH;
      end
      S_EX_I: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_IMM;
        ctrl_c.ext_op    = dec_ext_c;
        state_d          = S_WB_I;
      end
      S_WB_I: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.ext_op    = dec_ext_c;
        state_d          = S_FETCH;
      end
      S_ADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        state_d          = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.iord     = 1'b1;
        if (mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB_MEM: begin
        ctrl_c.mem_to_reg = 1'b1;
        ctrl_c.reg_write  = mem_ready;
        state_d           = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_src_b     = SRCB_B;
        ctrl_c.alu_op        = ALUOP_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
        ctrl_c.branch_ne     = (opcode == OP_BNE);
        state_d              = S_FETCH;
      end
      S_JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_JUMP;
        state_d          = S_FETCH;
      end
      default: state_d = S_RST;
    endcase
  end

  assign pc_write      = ctrl_c.pc_write;
  assign pc_write_cond = ctrl_c.pc_write_cond;
  assign branch_ne     = ctrl_c.branch_ne;
  assign iord          = ctrl_c.iord;
  assign mem_read      = ctrl_c.mem_read;
  assign mem_write     = ctrl_c.mem_write;
  assign ir_write      = ctrl_c.ir_write;
  assign reg_dst       = ctrl_c.reg_dst;
  assign mem_to_reg    = ctrl_c.mem_to_reg;
  assign reg_write     = ctrl_c.reg_write;
  assign alu_src_a     = ctrl_c.alu_src_a;
  assign alu_src_b     = ctrl_c.alu_src_b;
  assign alu_op        = ctrl_c.alu_op;
  assign pc_source     = ctrl_c.pc_source;
  assign ext_op        = ctrl_c.ext_op;
  assign illegal_op    = ctrl_c.illegal_op;
  assign state         = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: per-cycle expected control words
// are queued as stimulus is applied and compared against sampled outputs.
module tb_multi_cycle_ctrl;
  import mc_ctrl_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    ctrl_t      c;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
  logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source, ext_op;
  logic [3:0] state;

  obs_t exp_q[$];
  obs_t got_q[$];
  int   vectors = 0;
  int   misses  = 0;

  multi_cycle_ctrl #(.RESET_VECTOR_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .ext_op(ext_op), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Reference control word for a state, written directly from the state table.
  function automatic obs_t exp_out(input logic [3:0] st, input logic [5:0] opc, input logic mr);
    obs_t o = '0;
    o.st = st;
    case (st)
      4'd1: begin o.c.mem_read = 1'b1; o.c.alu_src_b = 2'b01; o.c.ir_write = mr; o.c.pc_write = mr; end
      4'd2: begin
        o.c.alu_src_b  = 2'b11;
        o.c.illegal_op = !(opc inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                       6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010,
                                       6'b001111});
      end
      4'd3: begin o.c.alu_src_a = 1'b1; o.c.alu_op = 2'b10; end
      4'd4: begin o.c.reg_dst = 1'b1; o.c.reg_write = 1'b1; end
      4'd5, 4'd6: begin
        if (st == 4'd5) begin o.c.alu_src_a = 1'b1; o.c.alu_src_b = 2'b10; o.c.alu_op = 2'b11; end
        else o.c.reg_write = 1'b1;
        o.c.ext_op = (opc == 6'b001100 || opc == 6'b001101) ? 2'b01 :
                     (opc == 6'b001111) ? 2'b10 : 2'b00;
      end
      4'd7: begin o.c.alu_src_a = 1'b1; o.c.alu_src_b = 2'b10; end
      4'd8: begin o.c.mem_read = 1'b1; o.c.iord = 1'b1; end
      4'd9: begin o.c.mem_write = 1'b1; o.c.iord = 1'b1; end
      4'd10: begin o.c.mem_to_reg = 1'b1; o.c.reg_write = mr; end
      4'd11: begin
        o.c.alu_src_a = 1'b1; o.c.alu_op = 2'b01; o.c.pc_write_cond = 1'b1;
        o.c.pc_source = 2'b01; o.c.branch_ne = (opc == 6'b000101);
      end
      4'd12: begin o.c.pc_write = 1'b1; o.c.pc_source = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = state;
    o.c.pc_write = pc_write;   o.c.pc_write_cond = pc_write_cond; o.c.branch_ne = branch_ne;
    o.c.iord = iord;           o.c.mem_read = mem_read;           o.c.mem_write = mem_write;
    o.c.ir_write = ir_write;   o.c.reg_dst = reg_dst;             o.c.mem_to_reg = mem_to_reg;
    o.c.reg_write = reg_write; o.c.alu_src_a = alu_src_a;         o.c.alu_src_b = alu_src_b;
    o.c.alu_op = alu_op;       o.c.pc_source = pc_source;         o.c.ext_op = ext_op;
    o.c.illegal_op = illegal_op;
    return o;
  endfunction

  // One clock: drive inputs for the cycle, queue the expected word, capture the DUT word.
  task automatic step(input logic rst, input logic [5:0] opc, input logic mr, input logic [3:0] st);
    @(posedge clk);
    #1;
    rst_n = rst; opcode = opc; mem_ready = mr; zero = 1'($urandom_range(0, 1));
    exp_q.push_back(exp_out(st, opc, mr));
    @(negedge clk);
    got_q.push_back(sample());
  endtask

  task automatic test_reset();
    obs_t e, g;
    step(1'b0, 6'b000000, 1'b1, 4'd0);
    step(1'b0, 6'b000000, 1'b1, 4'd0);
    step(1'b1, 6'b000000, 1'b1, 4'd0);
    step(1'b1, 6'b000000, 1'b0, 4'd1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin misses++; $display("FAIL reset[%0d] got=%h want=%h", i, g, e); end
    end
  endtask

  task automatic test_rtype();
    obs_t e, g;
    step(1'b1, 6'b000000, 1'b1, 4'd1);
    step(1'b1, 6'b000000, 1'b1, 4'd2);
    step(1'b1, 6'b000000, 1'b1, 4'd3);
    step(1'b1, 6'b000000, 1'b1, 4'd4);
    step(1'b1, 6'b000000, 1'b0, 4'd1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin misses++; $display("FAIL rtype[%0d] got=%h want=%h", i, g, e); end
    end
  endtask

  task automatic test_mem();
    obs_t e, g;
    // lw with two wait cycles in the read phase
    step(1'b1, 6'b100011, 1'b1, 4'd1);
    step(1'b1, 6'b100011, 1'b1, 4'd2);
    step(1'b1, 6'b100011, 1'b1, 4'd7);
    step(1'b1, 6'b100011, 1'b0, 4'd8);
    step(1'b1, 6'b100011, 1'b0, 4'd8);
    step(1'b1, 6'b100011, 1'b1, 4'd8);
    step(1'b1, 6'b100011, 1'b1, 4'd10);
    step(1'b1, 6'b100011, 1'b0, 4'd1);
    // sw after a stalled fetch, one write wait
    step(1'b1, 6'b101011, 1'b1, 4'd1);
    step(1'b1, 6'b101011, 1'b1, 4'd2);
    step(1'b1, 6'b101011, 1'b1, 4'd7);
    step(1'b1, 6'b101011, 1'b0, 4'd9);
    step(1'b1, 6'b101011, 1'b1, 4'd9);
    step(1'b1, 6'b101011, 1'b0, 4'd1);
    // lw whose write-back cycle sees mem_ready low
    step(1'b1, 6'b100011, 1'b1, 4'd1);
    step(1'b1, 6'b100011, 1'b1, 4'd2);
    step(1'b1, 6'b100011, 1'b1, 4'd7);
    step(1'b1, 6'b100011, 1'b1, 4'd8);
    step(1'b1, 6'b100011, 1'b0, 4'd10);
    step(1'b1, 6'b100011, 1'b0, 4'd1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin misses++; $display("FAIL mem[%0d] got=%h want=%h", i, g, e); end
    end
  endtask

  task automatic test_imm();
    obs_t e, g;
    logic [5:0] ops [4] = '{6'b001101, 6'b001111, 6'b001000, 6'b001100};
    foreach (ops[k]) begin
      step(1'b1, ops[k], 1'b1, 4'd1);
      step(1'b1, ops[k], 1'b1, 4'd2);
      step(1'b1, ops[k], 1'b1, 4'd5);
      step(1'b1, ops[k], 1'b1, 4'd6);
      step(1'b1, ops[k], 1'b0, 4'd1);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin misses++; $display("FAIL imm[%0d] got=%h want=%h", i, g, e); end
    end
  endtask

  task automatic test_branch_jump();
    obs_t e, g;
    logic [5:0] ops [3] = '{6'b000101, 6'b000100, 6'b000010};
    logic [3:0] exs [3] = '{4'd11, 4'd11, 4'd12};
    foreach (ops[k]) begin
      step(1'b1, ops[k], 1'b1, 4'd1);
      step(1'b1, ops[k], 1'b1, 4'd2);
      step(1'b1, ops[k], 1'b1, exs[k]);
      step(1'b1, ops[k], 1'b0, 4'd1);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin misses++; $display("FAIL brj[%0d] got=%h want=%h", i, g, e); end
    end
  endtask

  task automatic test_illegal();
    obs_t e, g;
    logic [5:0] ops [2] = '{6'b111111, 6'b000001};
    foreach (ops[k]) begin
      step(1'b1, ops[k], 1'b1, 4'd1);
      step(1'b1, ops[k], 1'b1, 4'd2);
      step(1'b1, ops[k], 1'b1, 4'd1);
      step(1'b1, ops[k], 1'b0, 4'd2);
      step(1'b1, ops[k], 1'b0, 4'd1);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin misses++; $display("FAIL illegal[%0d] got=%h want=%h", i, g, e); end
    end
  endtask

  task automatic test_reset_abort();
    obs_t e, g;
    step(1'b1, 6'b101011, 1'b1, 4'd1);
    step(1'b1, 6'b101011, 1'b1, 4'd2);
    step(1'b1, 6'b101011, 1'b1, 4'd7);
    step(1'b0, 6'b101011, 1'b0, 4'd9);
    step(1'b1, 6'b101011, 1'b1, 4'd0);
    step(1'b1, 6'b101011, 1'b0, 4'd1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin misses++; $display("FAIL abort[%0d] got=%h want=%h", i, g, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, g;
    step(1'b1, 6'b000000, 1'b1, 4'd1);
    step(1'b1, 6'b000000, 1'b1, 4'd2);
    step(1'b1, 6'b000000, 1'b1, 4'd3);
    step(1'b1, 6'b000000, 1'b1, 4'd4);
    step(1'b1, 6'b000010, 1'b1, 4'd1);
    step(1'b1, 6'b000010, 1'b1, 4'd2);
    step(1'b1, 6'b000010, 1'b1, 4'd12);
    step(1'b1, 6'b001010, 1'b1, 4'd1);
    step(1'b1, 6'b001010, 1'b1, 4'd2);
    step(1'b1, 6'b001010, 1'b1, 4'd5);
    step(1'b1, 6'b001010, 1'b1, 4'd6);
    step(1'b1, 6'b101011, 1'b1, 4'd1);
    step(1'b1, 6'b101011, 1'b1, 4'd2);
    step(1'b1, 6'b101011, 1'b1, 4'd7);
    step(1'b1, 6'b101011, 1'b1, 4'd9);
    step(1'b1, 6'b101011, 1'b0, 4'd1);
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); vectors++;
      if (g !== e) begin misses++; $display("FAIL b2b[%0d] got=%h want=%h", i, g, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_mem();
    test_imm();
    test_branch_jump();
    test_illegal();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Main control FSM for the multi-cycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory and write-back over a shared single-port memory, ALU and register file.
- Selects the immediate extension mode (sign, zero or upper) for the 16-to-32 extender.
- Exposes a memory-ready handshake so a slow memory can stall any memory phase.

Parameters:
- RESET_VECTOR_HOLD, 1, number of cycles spent in S_RST after reset is released before the first fetch (1..15).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- opcode  input  6  IR[31:26], valid from S_DECODE onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory has completed the current read/write this cycle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if the branch condition holds.
- branch_ne  output  1  branch condition is !zero (bne) instead of zero (beq).
- iord  output  1  memory address source: 0 = PC, 1 = ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load.
- reg_dst  output  1  write register: 0 = rt, 1 = rd.
- mem_to_reg  output  1  write data: 0 = ALUOut, 1 = MDR.
- reg_write  output  1  register-file write enable.
- alu_src_a  output  1  ALU A input: 0 = PC, 1 = register A.
- alu_src_b  output  2  ALU B input: 00 = B, 01 = 4, 10 = ext(imm), 11 = ext(imm)<<2.
- alu_op  output  2  ALU operation: 00 = add, 01 = sub, 10 = funct, 11 = from opcode (I-type).
- pc_source  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ext_op  output  2  extender mode: 00 = sign, 01 = zero, 10 = lui (imm<<16).
- illegal_op  output  1  one-cycle pulse on an undecodable opcode.
- state  output  4  current state encoding, for debug.

Behaviour:
- Reset:
  - rst_n low at a clk edge forces S_RST and clears the hold counter.
  - In S_RST every output is 0, including state = 0.
  - Reset mid-instruction aborts the instruction; no write strobe is asserted in the following cycle.
- Outputs are decoded from the state register. Exceptions: ir_write, pc_write (fetch) and reg_write (S_WB_MEM) are additionally ANDed with mem_ready, as noted per state.
- States and transitions:
  - S_RST: after RESET_VECTOR_HOLD cycles -> S_FETCH.
  - S_FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write and pc_write are asserted only in a cycle with mem_ready=1. On mem_ready -> S_DECODE; otherwise stay.
  - S_DECODE: alu_src_a=0, alu_src_b=11, alu_op=00, ext_op=00 (branch target precompute). Next state by opcode:
    - 000000 -> S_EX_R
    - 100011 or 101011 -> S_ADDR
    - 000100 or 000101 -> S_BRANCH
    - 000010 -> S_JUMP
    - 001000, 001100, 001101, 001010, 001111 -> S_EX_I
    - any other opcode: pulse illegal_op -> S_FETCH.
  - S_EX_R: alu_src_a=1, alu_src_b=00, alu_op=10 -> S_WB_R.
  - S_WB_R: reg_dst=1, reg_write=1 -> S_FETCH.
  - S_EX_I: alu_src_a=1, alu_src_b=10, alu_op=11; ext_op = 01 for andi/ori, 10 for lui, else 00 -> S_WB_I. ext_op is held through S_WB_I.
  - S_WB_I: reg_dst=0, reg_write=1 -> S_FETCH.
  - S_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00, ext_op=00. lw -> S_MEM_RD; sw -> S_MEM_WR.
  - S_MEM_RD: mem_read=1, iord=1. On mem_ready -> S_WB_MEM; otherwise stay.
  - S_MEM_WR: mem_write=1, iord=1. On mem_ready -> S_FETCH; otherwise stay.
  - S_WB_MEM: mem_to_reg=1, reg_dst=0, reg_write=1 -> S_FETCH.
  - S_BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, branch_ne = (opcode==000101) -> S_FETCH.
  - S_JUMP: pc_write=1, pc_source=10 -> S_FETCH.
- Latency with mem_ready tied high:
  - R-type 4 cycles, I-type ALU 4, lw 5, sw 4, beq/bne 3, j 3.
  - Each cycle with mem_ready=0 in a memory state adds one cycle.
- mem_read and mem_write are never both 1.
- reg_write is never 1 in a memory-wait cycle.

Decomposition:
- Package mc_ctrl_pkg: state encodings, opcode constants, and the alu_src_b, alu_op, pc_source and ext_op codes.
- One sub-module, mc_opcode_decode (combinational): maps opcode to instruction class, ext_op and a legal flag.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release with RESET_VECTOR_HOLD=1 -> state=S_RST with all outputs 0 for 1 cycle, then S_FETCH with mem_read=1.
- add (opcode 000000), mem_ready=1 -> FETCH, DECODE, EX_R, WB_R; reg_write=1 and reg_dst=1 only in the 4th cycle; back in S_FETCH in the 5th.
- lw with mem_ready low for 2 cycles in S_MEM_RD -> 7 cycles total; mem_read=1 and iord=1 throughout the wait; reg_write and mem_to_reg =1 only in S_WB_MEM.
- ori (001101) -> ext_op=01 in S_EX_I and S_WB_I; lui (001111) -> ext_op=10; addi (001000) -> ext_op=00.
- bne (000101) -> S_BRANCH with pc_write_cond=1, branch_ne=1, alu_op=01; 3 cycles total.
- Illegal opcode 111111 -> illegal_op=1 for exactly 1 cycle in S_DECODE, then S_FETCH. Separately, rst_n=0 during S_MEM_WR -> mem_write=0 in the next cycle.
